// File: rtl/vegeta_output_collector.sv
// rtl/vegeta_output_collector.sv - drain side of the VEGETA array: deskew, row packing, FWFT row FIFO
// Rows leave the FIFO over valid/ready with a per-job last tag and a done pulse.
module vegeta_output_collector #(
  parameter int M_SCALED      = 4,
  parameter int ALPHA         = 4,
  parameter int ADD_DATAWIDTH = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int ROW_CNT_W     = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [ROW_CNT_W-1:0]                      num_rows,
  input  logic [ALPHA*ADD_DATAWIDTH-1:0]            acc_in [0:M_SCALED-1],
  input  logic                                      col0_valid,
  output logic [M_SCALED*ALPHA*ADD_DATAWIDTH-1:0]   out_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      out_last,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      overflow
);

  localparam int CW    = ALPHA * ADD_DATAWIDTH;
  localparam int ROW_W = M_SCALED * CW;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ROW_CNT_W-1:0] num_rows_q, num_rows_d;
  logic [ROW_CNT_W-1:0] rows_seen_q, rows_seen_d;
  logic                 last_dropped_q, last_dropped_d;
  logic                 overflow_q, overflow_d;
  logic                 done_q, done_d;

  logic [ROW_W:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [ROW_W-1:0]     aligned_row;
  logic                 aligned_valid;
  logic                 flush;
  logic                 push_req;
  logic                 push_last;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic [ROW_W:0]       head;

  // Column j is delayed M_SCALED-1-j cycles so every column of a row lines up with the last one.
  for (genvar j = 0; j < M_SCALED; j++) begin : g_col
    localparam int NREG = M_SCALED - 1 - j;
    if (NREG == 0) begin : g_pass
      assign aligned_row[j*CW +: CW] = acc_in[j];
    end else begin : g_dly
      logic [CW-1:0] dly_q [NREG];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < NREG; k++) dly_q[k] <= '0;
        end else begin
          dly_q[0] <= acc_in[j];
          for (int k = 1; k < NREG; k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign aligned_row[j*CW +: CW] = dly_q[NREG-1];
    end
  end

  if (M_SCALED == 1) begin : g_vnone
    assign aligned_valid = col0_valid;
  end else begin : g_vpipe
    logic [M_SCALED-2:0] vpipe_q;
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        vpipe_q <= '0;
      end else begin
        vpipe_q[0] <= col0_valid;
        for (int k = 1; k < M_SCALED - 1; k++) vpipe_q[k] <= vpipe_q[k-1];
      end
    end
    assign aligned_valid = vpipe_q[M_SCALED-2];
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? head[ROW_W-1:0] : '0;
  assign out_last  = out_valid & head[ROW_W];
  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop       = out_valid & out_ready;
  assign push      = push_req & (~fifo_full | pop);
  assign flush     = (state_q == S_IDLE) && start && (num_rows != '0);

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign overflow  = overflow_q;

  always_comb begin
    state_d        = state_q;
    num_rows_d     = num_rows_q;
    rows_seen_d    = rows_seen_q;
    last_dropped_d = last_dropped_q;
    overflow_d     = overflow_q;
    done_d         = 1'b0;
    push_req       = 1'b0;
    push_last      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          overflow_d = 1'b0;
          if (num_rows == '0) begin
            done_d = 1'b1;
          end else begin
            state_d        = S_COLLECT;
            num_rows_d     = num_rows;
            rows_seen_d    = '0;
            last_dropped_d = 1'b0;
          end
        end
      end
      S_COLLECT: begin
        if (aligned_valid) begin
          push_req    = 1'b1;
          rows_seen_d = rows_seen_q + ROW_CNT_W'(1);
          if (rows_seen_q == num_rows_q - ROW_CNT_W'(1)) begin
            push_last      = 1'b1;
            state_d        = S_DRAIN;
            last_dropped_d = fifo_full & ~pop;
          end
        end
      end
      S_DRAIN: begin
        // A dropped last row leaves no tag behind, so the job ends when the FIFO runs dry.
        if ((pop && out_last) ||
            (last_dropped_q && ((count_q == '0) || (pop && count_q == CNT_W'(1))))) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (push_req && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      num_rows_q     <= '0;
      rows_seen_q    <= '0;
      last_dropped_q <= 1'b0;
      overflow_q     <= 1'b0;
      done_q         <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      num_rows_q     <= num_rows_d;
      rows_seen_q    <= rows_seen_d;
      last_dropped_q <= last_dropped_d;
      overflow_q     <= overflow_d;
      done_q         <= done_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_last, aligned_row};
  end

endmodule

// File: tb/tb_vegeta_output_collector.sv
// tb/tb_vegeta_output_collector.sv - directed scoreboard bench for vegeta_output_collector
module tb_vegeta_output_collector;
  localparam int M  = 4;
  localparam int A  = 4;
  localparam int DW = 32;
  localparam int CW = A * DW;
  localparam int RW = M * CW;
  localparam int NC = 64;

  logic          clk = 1'b0;
  logic          rst, start, col0_valid, out_ready;
  logic [15:0]   num_rows;
  logic [CW-1:0] acc_in [0:M-1];
  logic [RW-1:0] out_data;
  logic          out_valid, out_last, busy, done, overflow;

  vegeta_output_collector #(
    .M_SCALED(M), .ALPHA(A), .ADD_DATAWIDTH(DW), .FIFO_DEPTH(4), .ROW_CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .acc_in(acc_in),
    .col0_valid(col0_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          last;
    logic [RW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int sched [NC];
  int start_cyc, start_rows, start2_cyc, start2_rows, ready_from, rst_cyc, job_id;
  bit ov_h [NC];
  bit last_h [NC];
  bit busy_h [NC];
  bit done_h [NC];
  bit ovf_h [NC];
  bit zero_h [NC];

  function automatic logic [CW-1:0] colval(input int job, input int r, input int j);
    logic [CW-1:0] v;
    for (int a = 0; a < A; a++) v[a*DW +: DW] = DW'(job * 1000000 + 100 * r + j + 10000 * a);
    return v;
  endfunction

  function automatic logic [RW-1:0] rowval(input int job, input int r);
    logic [RW-1:0] v;
    for (int j = 0; j < M; j++) v[j*CW +: CW] = colval(job, r, j);
    return v;
  endfunction

  task automatic expect_row(input int r, input bit last);
    exp_t e;
    e.last = last;
    e.data = rowval(job_id, r);
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cfg(input int job);
    for (int i = 0; i < NC; i++) sched[i] = -1;
    start_cyc   = -1;
    start_rows  = 0;
    start2_cyc  = -1;
    start2_rows = 0;
    ready_from  = NC;
    rst_cyc     = -1;
    job_id      = job;
  endtask

  task automatic run(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      rst        = (c == rst_cyc);
      start      = (c == start_cyc) || (c == start2_cyc);
      num_rows   = (c == start2_cyc) ? 16'(start2_rows) : 16'(start_rows);
      col0_valid = (sched[c] >= 0);
      out_ready  = (c >= ready_from);
      for (int j = 0; j < M; j++) begin
        if (c >= j && sched[c-j] >= 0) acc_in[j] = colval(job_id, sched[c-j], j);
        else                           acc_in[j] = {A{DW'(32'hBAD0_0000 + c)}};
      end
      ov_h[c]   = out_valid;
      last_h[c] = out_last;
      busy_h[c] = busy;
      done_h[c] = done;
      ovf_h[c]  = overflow;
      zero_h[c] = (out_data == '0);
      tick();
    end
    rst        = 1'b0;
    start      = 1'b0;
    col0_valid = 1'b0;
    out_ready  = 1'b0;
  endtask

  function automatic int sum_h(input bit h [NC], input int lo, input int hi);
    int s = 0;
    for (int c = lo; c <= hi; c++) s += h[c];
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_row: got row %h last %0d, expected no row", out_data, out_last);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_data !== e.data || out_last !== e.last) begin
          errors++;
          $display("FAIL sb_row: got %h last %0d expected %h last %0d",
                   out_data, out_last, e.data, e.last);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; col0_valid = 1'b0; out_ready = 1'b0; num_rows = '0;
    for (int j = 0; j < M; j++) acc_in[j] = '0;
    tick(); tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data_zero", out_data == '0, 1);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    tick();

    // basic 3-row job, consumer always ready
    clear_cfg(1);
    start_cyc = 0; start_rows = 3; ready_from = 0;
    for (int r = 0; r < 3; r++) sched[2+r] = r;
    expect_row(0, 0); expect_row(1, 0); expect_row(2, 1);
    run(14);
    chk("t1_busy_c1", busy_h[1], 1);
    chk("t1_valid_c5", ov_h[5], 0);
    chk("t1_valid_c6", ov_h[6], 1);
    chk("t1_valid_c8", ov_h[8], 1);
    chk("t1_valid_c9", ov_h[9], 0);
    chk("t1_last_c7", last_h[7], 0);
    chk("t1_last_c8", last_h[8], 1);
    chk("t1_done_c8", done_h[8], 0);
    chk("t1_done_c9", done_h[9], 1);
    chk("t1_busy_c9", busy_h[9], 0);

    // consumer stalls through the whole job: rows 4..7 dropped
    clear_cfg(2);
    start_cyc = 0; start_rows = 8; ready_from = 13;
    for (int r = 0; r < 8; r++) sched[2+r] = r;
    for (int r = 0; r < 4; r++) expect_row(r, 0);
    run(22);
    chk("t2_ovf_c9", ovf_h[9], 0);
    chk("t2_ovf_c10", ovf_h[10], 1);
    chk("t2_ovf_c21", ovf_h[21], 1);
    chk("t2_no_last", sum_h(last_h, 0, 21), 0);
    chk("t2_done_c16", done_h[16], 0);
    chk("t2_done_c17", done_h[17], 1);
    chk("t2_busy_c17", busy_h[17], 0);
    chk("t2_done_count", sum_h(done_h, 0, 21), 1);

    // full FIFO with push and pop coinciding for rows 4..9
    clear_cfg(3);
    start_cyc = 0; start_rows = 10; ready_from = 9;
    for (int r = 0; r < 10; r++) begin
      sched[2+r] = r;
      expect_row(r, r == 9);
    end
    run(24);
    chk("t3_ovf_sticky_c0", ovf_h[0], 1);
    chk("t3_ovf_cleared", sum_h(ovf_h, 1, 23), 0);
    chk("t3_valid_c9", ov_h[9], 1);
    chk("t3_done_c18", done_h[18], 0);
    chk("t3_done_c19", done_h[19], 1);

    // zero-row job
    clear_cfg(4);
    start_cyc = 0; start_rows = 0;
    run(5);
    chk("t4_done_c0", done_h[0], 0);
    chk("t4_done_c1", done_h[1], 1);
    chk("t4_done_c2", done_h[2], 0);
    chk("t4_busy_never", sum_h(busy_h, 0, 4), 0);
    chk("t4_valid_never", sum_h(ov_h, 0, 4), 0);

    // reset mid-collect, then a single-row job
    clear_cfg(5);
    start_cyc = 0; start_rows = 5; rst_cyc = 7;
    sched[2] = 0; sched[3] = 1;
    run(10);
    chk("t5_busy_c7", busy_h[7], 1);
    chk("t5_valid_c7", ov_h[7], 1);
    chk("t5_valid_c8", ov_h[8], 0);
    chk("t5_data_zero_c8", zero_h[8], 1);
    chk("t5_last_c8", last_h[8], 0);
    chk("t5_busy_c8", busy_h[8], 0);
    chk("t5_done_c8", done_h[8], 0);
    chk("t5_ovf_c8", ovf_h[8], 0);
    chk("t5_done_none", sum_h(done_h, 0, 9), 0);
    clear_cfg(6);
    start_cyc = 0; start_rows = 1; ready_from = 0;
    sched[2] = 0;
    expect_row(0, 1);
    run(10);
    chk("t5b_valid_c6", ov_h[6], 1);
    chk("t5b_last_c6", last_h[6], 1);
    chk("t5b_valid_count", sum_h(ov_h, 0, 9), 1);
    chk("t5b_done_c7", done_h[7], 1);

    // col0_valid while idle and start while busy are both ignored
    clear_cfg(7);
    sched[1] = 50; sched[2] = 51;
    start_cyc = 3; start_rows = 2;
    start2_cyc = 5; start2_rows = 7;
    sched[6] = 0; sched[7] = 1;
    ready_from = 0;
    expect_row(0, 0); expect_row(1, 1);
    run(16);
    chk("t6_busy_c3", busy_h[3], 0);
    chk("t6_busy_c4", busy_h[4], 1);
    chk("t6_done_c12", done_h[12], 1);
    chk("t6_done_count", sum_h(done_h, 0, 15), 1);
    chk("t6_busy_c13", busy_h[13], 0);

    tick(); tick();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
